// File: rtl/serial_add_sub_pkg.sv
// Shared constants for the bit-serial adder/subtractor: FSM state encodings.
package serial_add_sub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// One-bit full adder cell; the serial datapath pushes every operand bit through it.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract, LSB first, one bit per clock through a single full adder.
// Subtraction is a + ~b + 1: B is inverted on load and the carry is seeded with 1.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; operands and mode captured on accept
//   RUN   | WIDTH cycles, one bit per cycle; last bit publishes result
//   DONE  | one-cycle done pulse, start ignored, then back to IDLE
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;

    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    // Only WIDTH-1 partial bits are ever stored; the final bit goes straight to sum.
    logic [WIDTH-2:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               fa_s;
    logic               fa_co;
    logic [WIDTH-1:0]   res_shift;
    logic               last_bit;

    full_adder u_fa (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_co)
    );

    assign res_shift = {fa_s, res_q};
    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

    // Datapath next-state: load on accept, shift one bit per RUN cycle.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && start) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = res_shift[WIDTH-1:1];
            carry_d = fa_co;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // Control FSM with registered busy/done and the published result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_bit) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        sum_q   <= res_shift;
                        cout_q  <= fa_co;
                        // carry_q is the carry into the MSB cell on the last step
                        ovf_q   <= carry_q ^ fa_co;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
